regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of `registerFile` among three writeback sources: integer ALU (req 0), load unit (req 1) and multi-cycle FPU (req 2). Each source hands off one write through a valid/ready handshake into a private one-entry holding buffer. The arbiter retires at most one buffered write per cycle onto the register file's `writeReg`/`writeData`/`regWrite`/`float` inputs. It sits between the execute/memory stages and the register file and is the only block permitted to drive that write port.

## Interface
- `DATA_W`, 32: write data width.
- `ADDR_W`, 6: register address width, matching `registerFile` `writeReg`.
- `CNT_W`, 16: contention counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req_valid`  in  3  per-requester write valid; bit i belongs to requester i.
- `req_ready`  out  3  per-requester ready; a transfer occurs when `req_valid[i] && req_ready[i]` at the rising edge.
- `req_reg`  in  3*ADDR_W  target registers; requester i uses `[i*ADDR_W +: ADDR_W]`.
- `req_data`  in  3*DATA_W  write data; requester i uses `[i*DATA_W +: DATA_W]`.
- `req_float`  in  3  1 selects the FP bank, 0 selects the integer bank.
- `regWrite`  out  1  registered write enable to `registerFile`.
- `writeReg`  out  ADDR_W  registered write address.
- `writeData`  out  DATA_W  registered write data.
- `float`  out  1  registered bank select.
- `grant_id`  out  2  index of the requester retired in the current output cycle. Holds its last value when idle.
- `contention_cnt`  out  CNT_W  saturating count of cycles with two or more buffers full.

## Operation
- Per-requester state: `full[i]`, plus buffered reg, data and float.
- `req_ready[i] = !full[i] || grant[i]`. The ready path is combinational from the `full` bits and the current grant only, never from `req_valid`.
- Capture: on a transfer, the buffer loads the request and `full[i]` is set, even if the same buffer is granted that cycle.
- Grant: each cycle, choose one `i` with `full[i]` set, using the policy under Configuration. The granted buffer clears at the edge unless it is refilled in the same cycle.
- Retire: on a grant, at the edge:
  - `writeReg`, `writeData`, `float` and `grant_id` load from the granted buffer.
  - `regWrite` is set to 1, except for integer writes to register 0 (`float`=0, reg=0). Those are consumed, but `regWrite` is set to 0; `$zero` is never written.
- Idle: with no full buffer, `regWrite` is set to 0 and the other outputs hold.
- Ordering: writes from one requester retire in acceptance order. Across requesters, retirement follows grant order. Same-register ordering across sources is the issuing stage's responsibility.
- `contention_cnt` increments when the popcount of `full` is at least 2, and saturates at all-ones.

## Timing
- Reset values:
  - `full` = 000, so `req_ready` = 111.
  - `regWrite` = 0, `writeReg` = 0, `writeData` = 0, `float` = 0.
  - `grant_id` = 0, `contention_cnt` = 0.
  - Round-robin last-grant pointer = 2, so requester 0 has first priority.
- Latency: a request accepted at edge N is granted in cycle N+1. `regWrite` is high after edge N+1, and `registerFile` commits it at edge N+2.
- Throughput: one write per cycle in aggregate, and one write per cycle per requester when uncontended, via the same-cycle refill allowed by `req_ready`.
- Starvation bound with round-robin: a full buffer is granted within 3 cycles.
- Reset mid-operation: every buffered, un-retired write is discarded; nothing partial reaches `registerFile`. Reset has priority over transfers in the same cycle.
- `req_valid` asserted while `req_ready` = 0: the request is not taken. The requester must hold its data stable until the transfer.

## Configuration
- `WB_RR_PRIORITY_EN` defined: round-robin arbitration. Search starts at (last grant + 1) mod 3, and the pointer updates only on a grant.
- `WB_RR_PRIORITY_EN` undefined: fixed priority, 0 > 1 > 2. No pointer state. Requester 2 can starve under sustained traffic from 0 or 1.

## Test plan
- Single write: reset, then req 0 sends reg 1 = 44, int. Required: `regWrite`=1, `writeReg`=1, `writeData`=44, `float`=0, `grant_id`=0 two edges after the request. A read of reg 1 returns 44 afterwards.
- Zero register: req 1 sends int reg 0 = 0xDEAD. Required: the buffer is consumed, `regWrite`=0 that cycle, and reg 0 reads 0. The same write with `float`=1 asserts `regWrite`=1.
- Three-way contention: all buffers full with regs 3, 4, 5.
  - Round-robin build: `grant_id` sequence 0, 1, 2; `contention_cnt`=2.
  - Fixed-priority build with req 0 refilling every cycle: req 2 is never granted for 10 cycles.
- Back-to-back streaming: req 2 holds `req_valid` for 8 cycles with data 1..8. Required: `req_ready` stays 1 throughout, and 8 consecutive `regWrite` pulses carry data 1..8 in order.
- Reset mid-operation: fill buffers 0 and 1, then assert `reset` for one cycle before any grant. Required: `regWrite` stays 0 afterwards, `req_ready`=111, and `contention_cnt`=0.
- Counter saturation: with `CNT_W`=4, hold two requesters busy for 20 cycles. Required: `contention_cnt` stops at 15.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request handshakes and the register-file write port
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic [2:0]          req_valid;
   logic [2:0]          req_ready;
   logic [3*ADDR_W-1:0] req_reg;
   logic [3*DATA_W-1:0] req_data;
   logic [2:0]          req_float;
   logic                regWrite;
   logic [ADDR_W-1:0]   writeReg;
   logic [DATA_W-1:0]   writeData;
   logic                float;
   logic [1:0]          grant_id;
   modport master (
      output req_valid, req_reg, req_data, req_float,
      input  req_ready, regWrite, writeReg, writeData, float, grant_id
   );
   modport slave (
      input  req_valid, req_reg, req_data, req_float,
      output req_ready, regWrite, writeReg, writeData, float, grant_id
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port among ALU, load and FPU writeback buffers.
// Define WB_RR_PRIORITY_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_write_arbiter_if.slave bus,
   output logic [CNT_W-1:0]      contention_cnt
);
   logic [2:0]        full;
   logic [2:0]        grant;
   logic [2:0]        xfer;
   logic [1:0]        gid;
   logic              any;
   logic              busy;
   logic [ADDR_W-1:0] buf_reg  [3];
   logic [DATA_W-1:0] buf_data [3];
   logic [2:0]        buf_float;
`ifdef WB_RR_PRIORITY_EN
   logic [1:0] last;
   logic [1:0] first;
   logic [1:0] second;
   logic [1:0] third;
   always_comb begin
      first  = (last == 2'd2) ? 2'd0 : last + 2'd1;
      second = (first == 2'd2) ? 2'd0 : first + 2'd1;
      third  = last;
      gid    = full[first] ? first : full[second] ? second : third;
   end
   always_ff @(posedge clk) begin
      if (reset) last <= 2'd2;
      else if (any) last <= gid;
   end
`else
   always_comb gid = full[0] ? 2'd0 : full[1] ? 2'd1 : 2'd2;
`endif
   assign any           = |full;
   assign grant         = any ? (3'b001 << gid) : 3'b000;
   assign busy          = (full[0] & full[1]) | (full[0] & full[2]) | (full[1] & full[2]);
   assign bus.req_ready = ~full | grant;
   assign xfer          = bus.req_valid & bus.req_ready;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (xfer[i]) begin
            buf_reg[i]   <= bus.req_reg[i*ADDR_W +: ADDR_W];
            buf_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
            buf_float[i] <= bus.req_float[i];
         end
      end
   end
   // Integer writes to register 0 are retired without asserting regWrite.
   always_ff @(posedge clk) begin
      if (reset) begin
         full           <= 3'b000;
         bus.regWrite   <= 1'b0;
         bus.writeReg   <= '0;
         bus.writeData  <= '0;
         bus.float      <= 1'b0;
         bus.grant_id   <= 2'd0;
         contention_cnt <= '0;
      end else begin
         full         <= xfer | (full & ~grant);
         bus.regWrite <= any && (buf_float[gid] || buf_reg[gid] != '0);
         if (busy && !(&contention_cnt)) contention_cnt <= contention_cnt + CNT_W'(1);
         if (any) begin
            bus.writeReg  <= buf_reg[gid];
            bus.writeData <= buf_data[gid];
            bus.float     <= buf_float[gid];
            bus.grant_id  <= gid;
         end
      end
   end
endmodule
